// File: rtl/config_loader.sv
// Streams a bitstream of WORD_WIDTH-bit words into a shadow register and commits the
// complete image atomically to the column config bus, gating the grid reset around loads.
module config_loader #(
    parameter  int COLUMNS            = 3,
    parameter  int COLUMN_CONFIG_BITS = 438,
    parameter  int WORD_WIDTH         = 32,
    localparam int TOTAL_BITS         = COLUMNS * COLUMN_CONFIG_BITS,
    localparam int WORDS              = (TOTAL_BITS + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int CW                 = $clog2(WORDS + 1)
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [TOTAL_BITS-1:0] config_out,
    output logic                  grid_nreset,
    output logic                  done,
    output logic [CW-1:0]         word_count
);

    localparam int LAST_BITS = TOTAL_BITS - (WORDS - 1) * WORD_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [TOTAL_BITS-1:0] r_shadow;
    logic [TOTAL_BITS-1:0] w_shadow_next;
    logic [TOTAL_BITS-1:0] r_config;
    logic [CW-1:0]         r_word_count;
    logic [CW-1:0]         w_word_count_next;
    logic                  r_done;
    logic                  w_done_next;
    logic                  r_grid_nreset;
    logic                  w_grid_nreset_next;
    logic                  w_accept;
    logic                  w_last;

    // A start in LOAD restarts the load, so it also blocks a word offered in the same cycle.
    assign w_accept = (r_state == S_LOAD) && data_valid && !start;
    assign w_last   = w_accept && (r_word_count == CW'(WORDS - 1));

    // Per-word shadow update; the final word keeps only the bits that fit the grid.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        localparam int LO = gi * WORD_WIDTH;
        localparam int WB = (gi == WORDS - 1) ? LAST_BITS : WORD_WIDTH;
        assign w_shadow_next[LO +: WB] = (w_accept && (r_word_count == CW'(gi)))
                                         ? data_in[WB-1:0] : r_shadow[LO +: WB];
    end

    always_comb begin
        w_state_next       = r_state;
        w_word_count_next  = r_word_count;
        w_done_next        = r_done;
        w_grid_nreset_next = (r_state == S_DONE) && !start;
        if (start) begin
            w_state_next      = S_LOAD;
            w_word_count_next = '0;
            w_done_next       = 1'b0;
        end else if (w_accept) begin
            w_word_count_next = r_word_count + CW'(1);
            if (w_last) begin
                w_state_next = S_DONE;
                w_done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state       <= S_IDLE;
            r_shadow      <= '0;
            r_config      <= '0;
            r_word_count  <= '0;
            r_done        <= 1'b0;
            r_grid_nreset <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shadow      <= w_shadow_next;
            r_word_count  <= w_word_count_next;
            r_done        <= w_done_next;
            r_grid_nreset <= w_grid_nreset_next;
            if (w_last) begin
                r_config <= w_shadow_next;
            end
        end
    end

    assign data_ready  = (r_state == S_LOAD);
    assign config_out  = r_config;
    assign grid_nreset = r_grid_nreset;
    assign done        = r_done;
    assign word_count  = r_word_count;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a word-list model checks every output each cycle,
// and literal expectations pin the model at the interesting points of each scenario.
module tb_config_loader;

    localparam int TB_BITS  = 1314;
    localparam int TB_WORDS = 42;

    logic                clk;
    logic                nreset;
    logic                start;
    logic [31:0]         data_in;
    logic                data_valid;
    logic                data_ready;
    logic [TB_BITS-1:0]  config_out;
    logic                grid_nreset;
    logic                done;
    logic [5:0]          word_count;

    config_loader dut (
        .clock       (clk),
        .nreset      (nreset),
        .start       (start),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .config_out  (config_out),
        .grid_nreset (grid_nreset),
        .done        (done),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [TB_BITS-1:0] act,
                         input logic [TB_BITS-1:0] exp);
        logic [1407:0] a2;
        logic [1407:0] e2;
        int            first;
        n_checks++;
        if (act !== exp) begin
            n_err++;
            a2 = '0;
            e2 = '0;
            a2[TB_BITS-1:0] = act;
            e2[TB_BITS-1:0] = exp;
            first = 0;
            for (int i = TB_BITS - 1; i >= 0; i--)
                if (act[i] !== exp[i]) first = i;
            first = (first / 64) * 64;
            $display("FAIL %s: bits [%0d+:64] got %h required %h",
                     name, first, a2[first +: 64], e2[first +: 64]);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 committed. Words are kept as a list and the
    // committed image is rebuilt bit by bit from that list.
    int                 m_phase = 0;
    int                 m_count = 0;
    bit                 m_done  = 1'b0;
    bit                 m_grid  = 1'b0;
    logic [TB_BITS-1:0] m_cfg   = '0;
    logic [31:0]        m_words [TB_WORDS];
    int                 n_loads = 0;

    always @(posedge clk) begin
        bit grid_new;
        if (!nreset) begin
            m_phase = 0;
            m_count = 0;
            m_done  = 1'b0;
            m_grid  = 1'b0;
            m_cfg   = '0;
        end else begin
            // The grid is released only once a commit has been stable for a full cycle.
            grid_new = (m_phase == 2) && !start;
            if (start) begin
                m_phase = 1;
                m_count = 0;
                m_done  = 1'b0;
            end else if (m_phase == 1 && data_valid) begin
                m_words[m_count] = data_in;
                m_count++;
                if (m_count == TB_WORDS) begin
                    for (int i = 0; i < TB_BITS; i++)
                        m_cfg[i] = m_words[i / 32][i % 32];
                    m_done  = 1'b1;
                    m_phase = 2;
                    n_loads++;
                    $display("load %0d committed: word0=%h word41=%h", n_loads,
                             m_words[0], m_words[TB_WORDS-1]);
                end
            end
            m_grid = grid_new;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready",  TB_BITS'(data_ready),  TB_BITS'(m_phase == 1));
            check("done",   TB_BITS'(done),        TB_BITS'(m_done));
            check("grid",   TB_BITS'(grid_nreset), TB_BITS'(m_grid));
            check("count",  TB_BITS'(word_count),  TB_BITS'(m_count));
            check("config", config_out,            m_cfg);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input bit incr);
        for (int k = 0; k < n; k++) begin
            data_valid = 1'b1;
            data_in    = incr ? base + 32'(k) : base;
            step();
        end
        data_valid = 1'b0;
    endtask

    initial begin
        int                 ready_cycles;
        int                 k;
        int                 guard;
        bit                 tog;
        logic [TB_BITS-1:0] ones;
        ones       = '1;
        nreset     = 1'b0;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;

        // Reset held for three edges
        repeat (3) step();
        cmp_en = 1'b1;
        check("rst_config", config_out, '0);
        check("rst_done",   TB_BITS'(done), '0);
        check("rst_grid",   TB_BITS'(grid_nreset), '0);
        check("rst_ready",  TB_BITS'(data_ready), '0);
        check("rst_count",  TB_BITS'(word_count), '0);
        nreset = 1'b1;
        step();

        // Back-to-back load, word k = k
        start = 1'b1;
        step();
        start = 1'b0;
        ready_cycles = 0;
        for (int i = 0; i < TB_WORDS; i++) begin
            data_valid = 1'b1;
            data_in    = 32'(i);
            if (data_ready) ready_cycles++;
            step();
        end
        data_valid = 1'b0;
        check("t2_ready_cycles", TB_BITS'(ready_cycles), TB_BITS'(42));
        check("t2_done",   TB_BITS'(done), TB_BITS'(1));
        check("t2_grid0",  TB_BITS'(grid_nreset), TB_BITS'(0));
        check("t2_w0",     TB_BITS'(config_out[31:0]), TB_BITS'(0));
        check("t2_w1",     TB_BITS'(config_out[63:32]), TB_BITS'(1));
        check("t2_w40",    TB_BITS'(config_out[1311:1280]), TB_BITS'(40));
        check("t2_last",   TB_BITS'(config_out[1313:1312]), TB_BITS'(2'b01));
        step();
        check("t2_grid1",  TB_BITS'(grid_nreset), TB_BITS'(1));
        step();

        // Start held two cycles (second one inside LOAD with a word offered), then a
        // load with data_valid toggling
        start      = 1'b1;
        data_valid = 1'b1;
        data_in    = 32'hDEAD_BEEF;
        step();
        step();
        start = 1'b0;
        check("t3_restart_count", TB_BITS'(word_count), '0);
        k     = 0;
        tog   = 1'b1;
        guard = 0;
        while (k < TB_WORDS && guard < 200) begin
            data_valid = tog;
            data_in    = tog ? 32'(k) : 32'h0BAD_0BAD;
            if (tog) check("t3_count", TB_BITS'(word_count), TB_BITS'(k));
            step();
            if (tog) k++;
            tog = !tog;
            guard++;
        end
        data_valid = 1'b0;
        check("t3_guard", TB_BITS'(guard < 200), TB_BITS'(1));
        check("t3_done",  TB_BITS'(done), TB_BITS'(1));
        check("t3_w1",    TB_BITS'(config_out[63:32]), TB_BITS'(1));
        check("t3_last",  TB_BITS'(config_out[1313:1312]), TB_BITS'(2'b01));
        step();

        // Reload with all ones: old image held while loading
        start = 1'b1;
        step();
        start = 1'b0;
        send_words(10, 32'hFFFF_FFFF, 1'b0);
        check("t4_done_mid",  TB_BITS'(done), '0);
        check("t4_grid_mid",  TB_BITS'(grid_nreset), '0);
        check("t4_hold_w1",   TB_BITS'(config_out[63:32]), TB_BITS'(1));
        check("t4_count_mid", TB_BITS'(word_count), TB_BITS'(10));
        send_words(32, 32'hFFFF_FFFF, 1'b0);
        check("t4_all_ones",  config_out, ones);
        check("t4_count_sat", TB_BITS'(word_count), TB_BITS'(42));
        step();

        // Restart at word 20 with a concurrent word, then a fresh full load
        start = 1'b1;
        step();
        start = 1'b0;
        send_words(20, 32'h5555_0000, 1'b1);
        check("t5_count20", TB_BITS'(word_count), TB_BITS'(20));
        start      = 1'b1;
        data_valid = 1'b1;
        data_in    = 32'h7777_7777;
        step();
        start      = 1'b0;
        data_valid = 1'b0;
        check("t5_count0", TB_BITS'(word_count), '0);
        check("t5_hold",   config_out, ones);
        send_words(42, 32'h0000_1000, 1'b1);
        check("t5_w0",   TB_BITS'(config_out[31:0]), TB_BITS'(32'h1000));
        check("t5_w1",   TB_BITS'(config_out[63:32]), TB_BITS'(32'h1001));
        check("t5_w40",  TB_BITS'(config_out[1311:1280]), TB_BITS'(32'h1028));
        check("t5_last", TB_BITS'(config_out[1313:1312]), TB_BITS'(2'b01));
        step();

        // Reset in the middle of a load
        start = 1'b1;
        step();
        start = 1'b0;
        send_words(30, 32'h0, 1'b1);
        check("t6_count30", TB_BITS'(word_count), TB_BITS'(30));
        nreset     = 1'b0;
        data_valid = 1'b1;
        data_in    = 32'h1234_5678;
        step();
        nreset     = 1'b1;
        data_valid = 1'b0;
        check("t6_config", config_out, '0);
        check("t6_done",   TB_BITS'(done), '0);
        check("t6_grid",   TB_BITS'(grid_nreset), '0);
        check("t6_ready",  TB_BITS'(data_ready), '0);
        check("t6_count",  TB_BITS'(word_count), '0);
        send_words(3, 32'hCAFE_0000, 1'b1);
        check("t6_idle_count", TB_BITS'(word_count), '0);
        check("t6_idle_ready", TB_BITS'(data_ready), '0);
        step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
